// File: rtl/fp_to_fixed.sv
// fp32 -> signed fixed-point converter with a one-bit-per-cycle aligner and valid/ready on both sides.
// Define FP_TO_FIXED_ROUND_NEAREST_EN for round-half-to-even; otherwise the magnitude is truncated.
module fp_to_fixed #(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             overflow,
    output logic             invalid
);

    localparam int AW = OUT_W + 1;
    localparam int CW = 6;
    localparam logic signed [9:0] SH_BIAS = 10'(FRAC_W - 150);
    localparam logic signed [9:0] SH_MAX  = 10'(OUT_W - 25);
    localparam logic signed [9:0] SH_MIN  = -10'sd26;
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);
    localparam logic [OUT_W-1:0]  SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     mag_q, mag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              left_q, left_d;
    logic              sign_q, sign_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              inv_q, inv_d;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
`endif

    // Decode of the incoming operand (used only on the accept cycle).
    logic signed [9:0] sh, sh_abs;
    logic              exp_max, exp_zero, man_nz, too_big, too_small;

    assign sh        = $signed({2'b00, in_data[30:23]}) + SH_BIAS;
    assign sh_abs    = sh[9] ? -sh : sh;
    assign exp_max   = &in_data[30:23];
    assign exp_zero  = ~|in_data[30:23];
    assign man_nz    = |in_data[22:0];
    assign too_big   = sh > SH_MAX;
    assign too_small = sh < SH_MIN;

    // Rounding, sign application and range check on the aligned magnitude.
    logic              round_inc;
    logic [AW-1:0]     rounded;
    logic [OUT_W-1:0]  mag_trunc, signed_val;
    logic              pos_ovf, neg_ovf, rng_ovf;

`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
    assign round_inc = guard_q && (sticky_q || mag_q[0]);
`else
    assign round_inc = 1'b0;
`endif
    assign rounded    = mag_q + AW'(round_inc);
    assign pos_ovf    = |rounded[AW-1:OUT_W-1];
    // Negative side can hold exactly 2^(OUT_W-1).
    assign neg_ovf    = rounded[OUT_W] | (rounded[OUT_W-1] & (|rounded[OUT_W-2:0]));
    assign rng_ovf    = sign_q ? neg_ovf : pos_ovf;
    assign mag_trunc  = rounded[OUT_W-1:0];
    assign signed_val = sign_q ? -mag_trunc : mag_trunc;

    assign in_ready  = (state_q == IDLE) && enable && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign overflow  = ovf_q;
    assign invalid   = inv_q;

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        sign_d   = sign_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
        guard_d  = guard_q;
        sticky_d = sticky_q;
`endif
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_d = in_data[31];
                        mag_d  = AW'({1'b1, in_data[22:0]});
                        cnt_d  = CW'(sh_abs);
                        left_d = !sh[9];
                        data_d = '0;
                        ovf_d  = 1'b0;
                        inv_d  = 1'b0;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
                        guard_d  = 1'b0;
                        sticky_d = 1'b0;
`endif
                        if (exp_max) begin
                            state_d = DONE;
                            if (man_nz) begin
                                inv_d = 1'b1;
                            end else begin
                                ovf_d  = 1'b1;
                                data_d = in_data[31] ? SAT_NEG : SAT_POS;
                            end
                        end else if (exp_zero || too_small) begin
                            state_d = DONE;
                        end else if (too_big) begin
                            state_d = DONE;
                            ovf_d   = 1'b1;
                            data_d  = in_data[31] ? SAT_NEG : SAT_POS;
                        end else if (sh == '0) begin
                            state_d = ROUND;
                        end else begin
                            state_d = ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (left_q) begin
                        mag_d = mag_q << 1;
                    end else begin
                        mag_d = mag_q >> 1;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
                        guard_d  = mag_q[0];
                        sticky_d = sticky_q | guard_q;
`endif
                    end
                    // Leave on the final shift so latency is |sh|+2 from the accept edge.
                    if (cnt_q == CNT_ONE) begin
                        state_d = ROUND;
                    end
                end
                ROUND: begin
                    data_d  = rng_ovf ? (sign_q ? SAT_NEG : SAT_POS) : signed_val;
                    ovf_d   = rng_ovf;
                    inv_d   = 1'b0;
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            sign_q   <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            sign_q   <= sign_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Scoreboard bench for fp_to_fixed: directed corner cases plus random operands against a real-valued model.
module tb_fp_to_fixed;

    localparam int OUT_W  = 32;
    localparam int FRAC_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic             overflow;
    logic             invalid;

    fp_to_fixed #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .invalid(invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             ovf;
        logic             inv;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: value = 1.m * 2^(e-127), scaled by 2^FRAC_W, then rounded and range-limited.
    function automatic void model(input logic [31:0] w, output exp_t ex, output int lat);
        int     e, sh;
        real    v, t, f;
        longint mag, val, maxv, minv;
        e    = int'(w[30:23]);
        sh   = e - 127 + FRAC_W - 23;
        maxv = (longint'(1) <<< (OUT_W-1)) - 1;
        minv = -(longint'(1) <<< (OUT_W-1));
        ex.d = '0; ex.ovf = 1'b0; ex.inv = 1'b0; lat = 1;
        if (e == 255) begin
            if (w[22:0] != 0) ex.inv = 1'b1;
            else begin ex.ovf = 1'b1; ex.d = w[31] ? OUT_W'(minv) : OUT_W'(maxv); end
        end else if (e == 0 || sh < -26) begin
            ex.d = '0;
        end else if (sh > OUT_W - 25) begin
            ex.ovf = 1'b1;
            ex.d   = w[31] ? OUT_W'(minv) : OUT_W'(maxv);
        end else begin
            lat = (sh < 0 ? -sh : sh) + 2;
            v = real'(longint'({1'b1, w[22:0]}));
            if (sh > 0) repeat (sh) v = v * 2.0;
            else        repeat (-sh) v = v * 0.5;
            t   = $floor(v);
            mag = longint'(t);
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
            f = v - t;
            if (f > 0.5 || (f == 0.5 && mag[0])) mag = mag + 1;
`endif
            val = w[31] ? -mag : mag;
            if (val > maxv)      begin ex.ovf = 1'b1; ex.d = OUT_W'(maxv); end
            else if (val < minv) begin ex.ovf = 1'b1; ex.d = OUT_W'(minv); end
            else                 ex.d = OUT_W'(val);
        end
    endfunction

    // Monitor: every completed output handshake is checked against the oldest expectation.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (!rst && enable && out_valid && out_ready) begin
                txn++;
                $display("txn %0d out_data=0x%h overflow=%0d invalid=%0d", txn, out_data, overflow, invalid);
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'(0));
                end else begin
                    ex = sb_q.pop_front();
                    check("out_data", 64'(out_data), 64'(ex.d));
                    check("overflow", 64'(overflow), 64'(ex.ovf));
                    check("invalid",  64'(invalid),  64'(ex.inv));
                end
            end
        end
    end

    // mode: 0 normal, 1 stall 3 cycles in ALIGN, 2 hold out_ready low 5 cycles, 3 reset mid-ALIGN
    task automatic send(input logic [31:0] w, input int mode);
        exp_t ex;
        int   lat_exp, lat, n;
        bit   got;
        model(w, ex, lat_exp);
        if (mode == 1) lat_exp += 3;
        if (mode == 2) out_ready = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("accept", 64'(got), 64'(1));
        if (!got) begin in_valid = 1'b0; out_ready = 1'b1; return; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb_q.push_back(ex);
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (mode == 1 && lat == 2) enable = 1'b0;
            if (mode == 1 && lat == 5) enable = 1'b1;
            if (mode == 3 && lat == 3) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check("abort_out_valid", 64'(out_valid), 64'(0));
                check("abort_in_ready",  64'(in_ready),  64'(0));
                rst = 1'b0;
                #1;
                check("abort_recover_ready", 64'(in_ready), 64'(1));
                void'(sb_q.pop_back());
                return;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(lat_exp));
        if (mode == 2) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                check("hold_out_valid", 64'(out_valid), 64'(1));
                check("hold_out_data",  64'(out_data),  64'(ex.d));
                check("hold_in_ready",  64'(in_ready),  64'(0));
            end
            out_ready = 1'b1;
        end
        n = 0;
        while (out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("release", 64'(out_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] dir [14];
        logic [31:0] w;
        dir = '{32'h3F800000, 32'hC0200000, 32'h501502F9, 32'hFF800000,
                32'h7FC00000, 32'h00000001, 32'h37C00000, 32'h38200000,
                32'h46FFFFFF, 32'hC6FFFFFF, 32'hC7000000, 32'h7F800000,
                32'h80000000, 32'h33800000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  64'(in_ready),  64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_data",  64'(out_data),  64'(0));
        check("reset_overflow",  64'(overflow),  64'(0));
        check("reset_invalid",   64'(invalid),   64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (dir[i]) send(dir[i], 0);
        send(32'h3F800000, 1);
        send(32'h3F800000, 2);
        send(32'h3F800000, 3);
        send(32'h3F800000, 0);

        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 4) begin
                w = $urandom;
            end else begin
                w[31]    = 1'($urandom_range(0, 1));
                w[30:23] = 8'($urandom_range(95, 145));
                w[22:0]  = 23'($urandom);
            end
            send(w, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
